tug_sound: RTL and testbench

TUG_SOUND -- requirements
Module: tug_sound

---
 rtl/tug_pkg.sv | 65 ++++++
 rtl/tug_sound_tone_gen.sv | 45 ++++
 rtl/tug_sound.sv | 139 +++++++++++++
 tb/tb_tug_sound.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war sound block: FSM states,
// tone selection, sequence identifiers, score endpoints and the note tables.
package tug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TONE_LO  = 2'd0,
        TONE_MID = 2'd1,
        TONE_HI  = 2'd2
    } tone_e;

    typedef enum logic [1:0] {
        SEQ_RIGHT   = 2'd0,
        SEQ_LEFT    = 2'd1,
        SEQ_TIE     = 2'd2,
        SEQ_VICTORY = 2'd3
    } seq_e;

    // Sequence register: which melody is playing and which note of it.
    typedef struct packed {
        seq_e       id;
        logic [1:0] idx;
    } seq_reg_t;

    // Rope positions that end the game.
    localparam logic [6:0] SCORE_LEFT_END  = 7'b0000001;
    localparam logic [6:0] SCORE_RIGHT_END = 7'b1000000;

    // Note played at position idx of a melody.
    function automatic tone_e seq_note(input seq_e seq, input logic [1:0] idx);
        tone_e t;
        t = TONE_LO;
        case (seq)
            SEQ_RIGHT: t = TONE_HI;
            SEQ_LEFT:  t = TONE_LO;
            SEQ_TIE:   t = TONE_LO;
            default: begin
                case (idx)
                    2'd0:    t = TONE_LO;
                    2'd1:    t = TONE_MID;
                    default: t = TONE_HI;
                endcase
            end
        endcase
        return t;
    endfunction

    // Index of the final note of a melody.
    function automatic logic [1:0] seq_last(input seq_e seq);
        logic [1:0] l;
        l = 2'd0;
        case (seq)
            SEQ_TIE:     l = 2'd1;
            SEQ_VICTORY: l = 2'd2;
            default:     l = 2'd0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tug_sound_tone_gen.sv
// Square-wave generator: toggles wave every half_period cycles while run is
// high; counter and phase return to zero whenever run is low, so each note
// begins with a full low half-period.
module tone_gen #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [W-1:0] half_period,
    output logic         wave
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wave_q, wave_d;

    // Half-period counter with toggle at terminal count; held at zero when stopped.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (!run) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (cnt_q == half_period - W'(1)) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter and phase registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/tug_sound.sv
// Tug-of-war sound sequencer. Event protocol: winrnd and tie are single-cycle
// pulses accepted only while busy=0 (otherwise dropped, never queued); an
// accepted event makes busy=1 on the following cycle. A rising edge of the
// game-over condition always wins and restarts playback with the victory melody.
module tug_sound
    import tug_pkg::*;
#(
    parameter int HALF_HI  = 25000,
    parameter int HALF_MID = 37500,
    parameter int HALF_LO  = 50000,
    parameter int NOTE_LEN = 5000000,
    parameter int GAP_LEN  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       winrnd,
    input  logic       right,
    input  logic       tie,
    input  logic [6:0] score,
    input  logic       en,
    output logic       spk,
    output logic       busy
);

    localparam int MAX_HALF = (HALF_HI > HALF_MID) ? ((HALF_HI > HALF_LO) ? HALF_HI : HALF_LO)
                                                   : ((HALF_MID > HALF_LO) ? HALF_MID : HALF_LO);
    localparam int MAX_LEN  = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
    localparam int MAX_ALL  = (MAX_HALF > MAX_LEN) ? MAX_HALF : MAX_LEN;
    // Wide enough to hold the largest parameter value itself (tone half-periods are passed whole).
    localparam int CW       = $clog2(MAX_ALL + 1);

    state_e        state_q, state_d;
    seq_reg_t      seq_q, seq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          go_q;

    logic          game_over;
    logic          vic_start;
    tone_e         cur_tone;
    logic [CW-1:0] half_sel;
    logic          tone_run;
    logic          wave;

    assign game_over = (score == SCORE_LEFT_END) || (score == SCORE_RIGHT_END);
    assign vic_start = game_over && !go_q;

    // Next-state logic: victory preempts everything, then idle starts, note/gap timing.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        if (vic_start) begin
            state_d   = ST_NOTE;
            seq_d.id  = SEQ_VICTORY;
            seq_d.idx = 2'd0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (tie) begin
                        state_d   = ST_NOTE;
                        seq_d.id  = SEQ_TIE;
                        seq_d.idx = 2'd0;
                    end else if (winrnd) begin
                        state_d   = ST_NOTE;
                        seq_d.id  = right ? SEQ_RIGHT : SEQ_LEFT;
                        seq_d.idx = 2'd0;
                    end
                end
                ST_NOTE: begin
                    if (cnt_q == CW'(NOTE_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = (seq_q.idx == seq_last(seq_q.id)) ? ST_IDLE : ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(GAP_LEN - 1)) begin
                        cnt_d     = '0;
                        seq_d.idx = seq_q.idx + 2'd1;
                        state_d   = ST_NOTE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, sequence, duration counter and game-over history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            go_q    <= game_over;
        end
    end

    assign cur_tone = seq_note(seq_q.id, seq_q.idx);

    // Half-period of the note currently selected by the sequence register.
    always_comb begin
        half_sel = CW'(HALF_LO);
        case (cur_tone)
            TONE_HI:  half_sel = CW'(HALF_HI);
            TONE_MID: half_sel = CW'(HALF_MID);
            default:  half_sel = CW'(HALF_LO);
        endcase
    end

    // Dropping run in the preempt cycle restarts the tone phase for the new note.
    assign tone_run = (state_q == ST_NOTE) && !vic_start;

    tone_gen #(
        .W(CW)
    ) u_tone (
        .clk        (clk),
        .rst        (rst),
        .run        (tone_run),
        .half_period(half_sel),
        .wave       (wave)
    );

    assign spk  = wave && en && (state_q == ST_NOTE);
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tug_sound.sv
// Directed bench for tug_sound with small timing parameters. Stimulus pushes
// the expected busy window (start cycle, length, speaker trace) into a queue;
// a monitor captures each busy window and compares against the queue head.
module tb_tug_sound;

    localparam int NOTE_LEN = 20;
    localparam int GAP_LEN  = 4;
    localparam int HALF_HI  = 2;
    localparam int HALF_MID = 3;
    localparam int HALF_LO  = 4;

    localparam logic [6:0] SCORE_MID = 7'b0001000;
    localparam logic [6:0] SCORE_R   = 7'b1000000;
    localparam logic [6:0] SCORE_L   = 7'b0000001;

    typedef struct {
        int           start;
        int           len;
        logic [127:0] wave;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       winrnd = 1'b0;
    logic       right  = 1'b0;
    logic       tie    = 1'b0;
    logic       en     = 1'b1;
    logic [6:0] score  = SCORE_MID;
    logic       spk;
    logic       busy;

    int           cyc   = 0;
    int           tests = 0;
    int           fails = 0;
    int           last_start;
    exp_t         exp_q[$];
    int           bld_len  = 0;
    logic [127:0] bld_wave = '0;
    bit           in_seq   = 1'b0;

    tug_sound #(
        .HALF_HI (HALF_HI),
        .HALF_MID(HALF_MID),
        .HALF_LO (HALF_LO),
        .NOTE_LEN(NOTE_LEN),
        .GAP_LEN (GAP_LEN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .winrnd(winrnd),
        .right (right),
        .tie   (tie),
        .score (score),
        .en    (en),
        .spk   (spk),
        .busy  (busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, busy=%0d", busy);
        $fatal(1, "watchdog expired");
    end

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_wave(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // expected-trace builder
    task automatic add_note(input int half, input int n, input bit on);
        for (int k = 0; k < n; k++) begin
            bld_wave[bld_len] = on && (((k / half) % 2) == 1);
            bld_len++;
        end
    endtask

    task automatic add_gap(input int n);
        bld_len += n;
    endtask

    task automatic push_exp(input int start);
        exp_t e;
        e.start = start;
        e.len   = bld_len;
        e.wave  = bld_wave;
        exp_q.push_back(e);
        bld_len  = 0;
        bld_wave = '0;
    endtask

    // driver tasks (all drive #1 after the rising edge)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic w, input logic r);
        tie        = t;
        winrnd     = w;
        right      = r;
        last_start = cyc + 1;
        step();
        tie    = 1'b0;
        winrnd = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles, expected 0", busy, n);
        end
        repeat (2) step();
    endtask

    // monitor / scoreboard: capture each busy window, compare with queue head
    initial begin : monitor
        int           obs_start;
        int           obs_len;
        logic [127:0] obs_wave;
        exp_t         e;
        obs_start = 0;
        obs_len   = 0;
        obs_wave  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_seq = 1'b0;
            end else if (busy) begin
                if (!in_seq) begin
                    in_seq    = 1'b1;
                    obs_start = cyc;
                    obs_len   = 0;
                    obs_wave  = '0;
                end
                if (obs_len < 128) obs_wave[obs_len] = spk;
                obs_len++;
            end else if (in_seq) begin
                in_seq = 1'b0;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_seq: busy window of %0d cycles at cycle %0d, expected none",
                             obs_len, obs_start);
                end else begin
                    e = exp_q.pop_front();
                    check_int("seq_start", obs_start, e.start);
                    check_int("seq_busy_len", obs_len, e.len);
                    check_wave("seq_spk_trace", obs_wave, e.wave);
                end
            end
        end
    end

    // stimulus
    initial begin : stimulus
        int s;
        int c;

        // reset state
        rst = 1'b0;
        repeat (3) step();
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_spk", int'(spk), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) step();

        // RIGHT: one HI note, period 4
        pulse(1'b0, 1'b1, 1'b1);
        add_note(HALF_HI, NOTE_LEN, 1'b1);
        push_exp(last_start);
        wait_idle();

        // tie and winrnd together: tie wins, LO gap LO = 44 cycles
        pulse(1'b1, 1'b1, 1'b1);
        add_note(HALF_LO, NOTE_LEN, 1'b1);
        add_gap(GAP_LEN);
        add_note(HALF_LO, NOTE_LEN, 1'b1);
        push_exp(last_start);
        wait_idle();

        // TIE with a tie pulse in the note and a winrnd pulse in the gap: both dropped
        pulse(1'b1, 1'b0, 1'b0);
        s = last_start;
        add_note(HALF_LO, NOTE_LEN, 1'b1);
        add_gap(GAP_LEN);
        add_note(HALF_LO, NOTE_LEN, 1'b1);
        push_exp(s);
        wait_cyc(s + 5);
        tie = 1'b1;
        step();
        tie = 1'b0;
        wait_cyc(s + 20);
        winrnd = 1'b1;
        right  = 1'b1;
        step();
        winrnd = 1'b0;
        wait_idle();

        // score hits right end 10 cycles into a RIGHT note: victory preempts
        pulse(1'b0, 1'b1, 1'b1);
        s = last_start;
        add_note(HALF_HI, 10, 1'b1);
        add_note(HALF_LO, NOTE_LEN, 1'b1);
        add_gap(GAP_LEN);
        add_note(HALF_MID, NOTE_LEN, 1'b1);
        add_gap(GAP_LEN);
        add_note(HALF_HI, NOTE_LEN, 1'b1);
        push_exp(s);
        wait_cyc(s + 9);
        score = SCORE_R;
        wait_idle();
        repeat (40) step();
        score = SCORE_MID;
        repeat (3) step();

        // victory from idle with sound muted: spk stays 0, busy 68 cycles
        en    = 1'b0;
        c     = cyc;
        score = SCORE_L;
        add_note(HALF_LO, NOTE_LEN, 1'b0);
        add_gap(GAP_LEN);
        add_note(HALF_MID, NOTE_LEN, 1'b0);
        add_gap(GAP_LEN);
        add_note(HALF_HI, NOTE_LEN, 1'b0);
        push_exp(c + 1);
        step();
        wait_idle();
        score = SCORE_MID;
        en    = 1'b1;
        repeat (3) step();

        // asynchronous reset in the high half of a LEFT note, then LEFT on the first edge
        pulse(1'b0, 1'b1, 1'b0);
        s = last_start;
        wait_cyc(s + 5);
        check_int("pre_reset_spk", int'(spk), 1);
        #3;
        rst = 1'b0;
        #1;
        check_int("async_reset_busy", int'(busy), 0);
        check_int("async_reset_spk", int'(spk), 0);
        repeat (2) @(negedge clk);
        check_int("held_reset_busy", int'(busy), 0);
        @(negedge clk);
        rst    = 1'b1;
        winrnd = 1'b1;
        right  = 1'b0;
        add_note(HALF_LO, NOTE_LEN, 1'b1);
        push_exp(cyc + 1);
        step();
        winrnd = 1'b0;
        wait_idle();

        repeat (5) step();
        check_int("exp_queue_empty", exp_q.size(), 0);
        check_int("monitor_idle", int'(in_seq), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
